// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a length-prefixed little-endian byte stream
// into words, writes them sequentially and holds the core in reset until done.
module imem_loader #(
   parameter int addr_width = 32,
   parameter int data_width = 32,
   parameter int max_words  = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [addr_width-1:0] base_addr_i,
   input  logic [7:0]            byte_i,
   input  logic                  byte_valid_i,
   output logic                  byte_ready_o,
   output logic                  mem_we_o,
   output logic [addr_width-1:0] mem_addr_o,
   output logic [data_width-1:0] mem_data_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic                  core_rst_no
);

   localparam int Bytes = data_width / 8;
   // Counter must also cover the 4-byte length header.
   localparam int CntW  = ($clog2(Bytes) > 2) ? $clog2(Bytes) : 2;

   typedef enum logic [1:0] {IDLE, LEN, DATA, WRITE} state_e;

   state_e                state_q;
   logic [CntW-1:0]       byte_cnt_q;
   logic [31:0]           len_q, word_cnt_q;
   logic [addr_width-1:0] base_q, addr_q;
   logic [data_width-1:0] word_q, data_q;
   logic                  ready_q, we_q, busy_q, done_q, err_q, core_rst_q;

   logic                  accept;
   logic [31:0]           len_d, word_cnt_d;
   logic [data_width-1:0] word_d;

   assign accept = byte_valid_i & ready_q;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      len_d      = len_q;
      word_d     = word_q;
      word_cnt_d = word_cnt_q + 32'd1;
      for (int k = 0; k < 4; k++) begin
         if (byte_cnt_q[1:0] == 2'(k)) len_d[8*k +: 8] = byte_i;
      end
      for (int k = 0; k < Bytes; k++) begin
         if (byte_cnt_q == CntW'(k)) word_d[8*k +: 8] = byte_i;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         byte_cnt_q <= '0;
         len_q      <= '0;
         word_cnt_q <= '0;
         base_q     <= '0;
         addr_q     <= '0;
         word_q     <= '0;
         data_q     <= '0;
         ready_q    <= 1'b0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         core_rst_q <= 1'b0;
      end else begin
         we_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_q    <= LEN;
                  base_q     <= base_addr_i;
                  byte_cnt_q <= '0;
                  ready_q    <= 1'b1;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  err_q      <= 1'b0;
                  core_rst_q <= 1'b0;
               end
            end
            LEN: begin
               if (accept) begin
                  len_q      <= len_d;
                  byte_cnt_q <= byte_cnt_q + CntW'(1);
                  if (byte_cnt_q == CntW'(3)) begin
                     byte_cnt_q <= '0;
                     if (len_d == 32'd0) begin
                        state_q    <= IDLE;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        core_rst_q <= 1'b1;
                     end else if (len_d > 32'(max_words)) begin
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                     end else begin
                        state_q    <= DATA;
                        word_cnt_q <= '0;
                     end
                  end
               end
            end
            DATA: begin
               if (accept) begin
                  word_q     <= word_d;
                  byte_cnt_q <= byte_cnt_q + CntW'(1);
                  if (byte_cnt_q == CntW'(Bytes - 1)) begin
                     byte_cnt_q <= '0;
                     state_q    <= WRITE;
                     ready_q    <= 1'b0;
                     we_q       <= 1'b1;
                     addr_q     <= base_q + addr_width'(word_cnt_q) * addr_width'(Bytes);
                     data_q     <= word_d;
                  end
               end
            end
            WRITE: begin
               word_cnt_q <= word_cnt_d;
               if (word_cnt_d == len_q) begin
                  state_q    <= IDLE;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  core_rst_q <= 1'b1;
               end else begin
                  state_q <= DATA;
                  ready_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign byte_ready_o = ready_q;
   assign mem_we_o     = we_q;
   assign mem_addr_o   = addr_q;
   assign mem_data_o   = data_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign core_rst_no  = core_rst_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table vectors, hand-written corner sequences
// and randomized loads compared against a word-list reference model.
module tb_imem_loader;

   localparam int MaxWords = 4;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        start_i;
   logic [31:0] base_addr_i;
   logic [7:0]  byte_i;
   logic        byte_valid_i;
   logic        byte_ready_o, mem_we_o, busy_o, done_o, err_o, core_rst_no;
   logic [31:0] mem_addr_o, mem_data_o;

   imem_loader #(.addr_width(32), .data_width(32), .max_words(MaxWords)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
      .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .core_rst_no(core_rst_no)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;

   logic [31:0] stim_words[$];
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   logic        prev_we = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Write monitor: each strobe lasts one cycle and never overlaps byte_ready_o.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (mem_we_o) begin
            wr_addr.push_back(mem_addr_o);
            wr_data.push_back(mem_data_o);
            check("ready_in_write", 64'(byte_ready_o), 64'd0);
            check("we_one_cycle", 64'(prev_we), 64'd0);
         end
         prev_we = mem_we_o;
      end
   end

   // Called at a negedge; returns at the negedge after the byte was accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) begin
         byte_valid_i = 1'b0;
         byte_i       = 8'($urandom);
         @(negedge clk_i);
      end
      byte_i       = b;
      byte_valid_i = 1'b1;
      n = 0;
      while (!byte_ready_o && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 100) check("ready_timeout", 64'(byte_ready_o), 64'd1);
      @(negedge clk_i);
      byte_valid_i = 1'b0;
   endtask

   task automatic pulse_start(input logic [31:0] base);
      base_addr_i = base;
      start_i     = 1'b1;
      @(negedge clk_i);
      start_i     = 1'b0;
      base_addr_i = $urandom;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy_o && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 100) check("idle_timeout", 64'(busy_o), 64'd0);
   endtask

   task automatic send_word(input logic [31:0] w, input int max_gap);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], int'($urandom_range(max_gap)));
   endtask

   task automatic run_load(input logic [31:0] base, input logic [31:0] len, input int max_gap);
      wr_addr.delete();
      wr_data.delete();
      pulse_start(base);
      send_word(len, max_gap);
      if (len == 32'd0) check("zero_done_latency", 64'(done_o), 64'd1);
      else if (len > 32'(MaxWords)) check("err_latency", 64'(err_o), 64'd1);
      else for (int i = 0; i < int'(len); i++) send_word(stim_words[i], max_gap);
      wait_idle();
   endtask

   // Reference model: a valid load writes word i to base + 4*i (mod 2^32).
   task automatic check_model(input logic [31:0] base, input logic [31:0] len);
      int          exp_n;
      logic        ok;
      logic [31:0] a;
      ok    = (len <= 32'(MaxWords));
      exp_n = (len == 32'd0 || !ok) ? 0 : int'(len);
      check("nwrites", 64'(wr_addr.size()), 64'(exp_n));
      for (int i = 0; i < exp_n && i < wr_addr.size(); i++) begin
         a = base + 32'(i) * 32'd4;
         check("wr_addr", 64'(wr_addr[i]), 64'(a));
         check("wr_data", 64'(wr_data[i]), 64'(stim_words[i]));
      end
      check("done", 64'(done_o), 64'(ok));
      check("err", 64'(err_o), 64'(!ok));
      check("core_rst_n", 64'(core_rst_no), 64'(ok));
      check("busy_end", 64'(busy_o), 64'd0);
   endtask

   typedef struct {
      logic [31:0] base;
      logic [31:0] len;
      logic [31:0] w0, w1;
      int          max_gap;
      int          exp_n;
      logic [31:0] a0, a1, d0, d1;
      logic        exp_done, exp_err, exp_core;
   } vec_t;

   initial begin
      vec_t vecs[8];
      logic [31:0] base, len;

      rst_ni = 1'b0; start_i = 1'b0; base_addr_i = '0; byte_i = '0; byte_valid_i = 1'b0;
      repeat (2) @(negedge clk_i);
      check("rst_ready", 64'(byte_ready_o), 64'd0);
      check("rst_we", 64'(mem_we_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_done", 64'(done_o), 64'd0);
      check("rst_err", 64'(err_o), 64'd0);
      check("rst_core", 64'(core_rst_no), 64'd0);
      check("rst_addr", 64'(mem_addr_o), 64'd0);
      check("rst_data", 64'(mem_data_o), 64'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Bytes offered in IDLE are refused.
      byte_valid_i = 1'b1;
      byte_i       = 8'h55;
      repeat (3) begin
         @(negedge clk_i);
         check("idle_ready", 64'(byte_ready_o), 64'd0);
      end
      byte_valid_i = 1'b0;

      vecs[0] = '{32'h100, 2, 32'h13, 32'h0010_0093, 0, 2, 32'h100, 32'h104, 32'h13, 32'h0010_0093, 1, 0, 1};
      vecs[1] = '{32'h100, 2, 32'h13, 32'h0010_0093, 5, 2, 32'h100, 32'h104, 32'h13, 32'h0010_0093, 1, 0, 1};
      vecs[2] = '{32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
      vecs[3] = '{32'h40, 5, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0};
      vecs[4] = '{32'hFFFF_FFFC, 2, 32'hDEAD_BEEF, 32'h1234_5678, 3, 2, 32'hFFFF_FFFC, 32'h0, 32'hDEAD_BEEF, 32'h1234_5678, 1, 0, 1};
      vecs[5] = '{32'h2000, 1, 32'hA5A5_5A5A, 0, 1, 1, 32'h2000, 0, 32'hA5A5_5A5A, 0, 1, 0, 1};
      vecs[6] = '{32'h0, 32'h0100_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      vecs[7] = '{32'h10, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};

      foreach (vecs[v]) begin
         stim_words = '{vecs[v].w0, vecs[v].w1};
         run_load(vecs[v].base, vecs[v].len, vecs[v].max_gap);
         check($sformatf("v%0d_nwrites", v), 64'(wr_addr.size()), 64'(vecs[v].exp_n));
         if (vecs[v].exp_n > 0 && wr_addr.size() > 0) begin
            check($sformatf("v%0d_a0", v), 64'(wr_addr[0]), 64'(vecs[v].a0));
            check($sformatf("v%0d_d0", v), 64'(wr_data[0]), 64'(vecs[v].d0));
         end
         if (vecs[v].exp_n > 1 && wr_addr.size() > 1) begin
            check($sformatf("v%0d_a1", v), 64'(wr_addr[1]), 64'(vecs[v].a1));
            check($sformatf("v%0d_d1", v), 64'(wr_data[1]), 64'(vecs[v].d1));
         end
         check($sformatf("v%0d_done", v), 64'(done_o), 64'(vecs[v].exp_done));
         check($sformatf("v%0d_err", v), 64'(err_o), 64'(vecs[v].exp_err));
         check($sformatf("v%0d_core", v), 64'(core_rst_no), 64'(vecs[v].exp_core));
         check($sformatf("v%0d_busy", v), 64'(busy_o), 64'd0);
      end

      // Start while busy is ignored; start on the completion cycle is ignored too.
      wr_addr.delete();
      wr_data.delete();
      pulse_start(32'h300);
      check("restart_done_clr", 64'(done_o), 64'd0);
      check("restart_core_rst", 64'(core_rst_no), 64'd0);
      check("restart_busy", 64'(busy_o), 64'd1);
      send_word(32'd1, 0);
      pulse_start(32'h900);
      for (int k = 0; k < 4; k++) send_byte(8'(k + 1), 0);
      check("write_cycle", 64'(mem_we_o), 64'd1);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      check("start_at_done_busy", 64'(busy_o), 64'd0);
      check("start_at_done_done", 64'(done_o), 64'd1);
      check("busy_start_addr", 64'(wr_addr.size() > 0 ? wr_addr[0] : 32'hX), 64'h300);
      check("busy_start_data", 64'(wr_data.size() > 0 ? wr_data[0] : 32'hX), 64'h0403_0201);
      pulse_start(32'h0);
      check("later_start_busy", 64'(busy_o), 64'd1);
      send_word(32'd0, 0);
      check("later_start_done", 64'(done_o), 64'd1);

      // Asynchronous reset in the middle of a word.
      wr_addr.delete();
      wr_data.delete();
      pulse_start(32'h500);
      send_word(32'd2, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 1);
      #2 rst_ni = 1'b0;
      #1;
      check("arst_ready", 64'(byte_ready_o), 64'd0);
      check("arst_busy", 64'(busy_o), 64'd0);
      check("arst_done", 64'(done_o), 64'd0);
      check("arst_core", 64'(core_rst_no), 64'd0);
      check("arst_addr", 64'(mem_addr_o), 64'd0);
      check("arst_data", 64'(mem_data_o), 64'd0);
      @(negedge clk_i);
      check("arst_we", 64'(mem_we_o), 64'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("arst_nwrites", 64'(wr_addr.size()), 64'd0);
      stim_words = '{32'hCAFE_F00D, 32'h0BAD_C0DE};
      run_load(32'h500, 32'd2, 0);
      check_model(32'h500, 32'd2);

      // Randomized loads with random gaps, including the max_words boundary.
      for (int r = 0; r < 25; r++) begin
         len  = 32'($urandom_range(MaxWords + 2));
         base = $urandom;
         if (r % 4 == 0) base[1:0] = 2'b00;
         stim_words.delete();
         for (int i = 0; i < MaxWords; i++) stim_words.push_back($urandom);
         run_load(base, len, int'($urandom_range(5)));
         check_model(base, len);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
